issue_x_scoreboard: RTL and testbench
=====================================

Name: issue_x_scoreboard

Overview:
- Issue stage directly upstream of the X execute unit.
- Accepts decoded ALU/shift instructions from decode and checks source registers against a per-register pending scoreboard.
- On a RAW hazard it stalls decode and sends a bubble downstream.
- When the instruction is hazard-free it registers it onto the is_x_* bus consumed by the 4-stage X pipeline.

Parameters:
- PEND_CYCLES, 5, edges from issue acceptance until the destination register is readable from the register file (X0..X3 + WB write).
- CNT_W, 3, scoreboard counter width; must satisfy 2^CNT_W > PEND_CYCLES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_is_valid  in  1  decode presents an instruction
- id_is_rs  in  5  source register A index
- id_is_rt  in  5  source register B index
- id_is_uses_rs  in  1  instruction reads rs
- id_is_uses_rt  in  1  instruction reads rt
- id_is_rega  in  32  rs value read from register file this cycle
- id_is_regb  in  32  rt value read from register file this cycle
- id_is_imedext  in  32  sign/zero-extended immediate
- id_is_selalushift  in  1  1 = shifter result, 0 = ALU result
- id_is_selimregb  in  1  1 = immediate as ALU operand B
- id_is_aluop  in  3  ALU operation
- id_is_unsig  in  1  unsigned arithmetic
- id_is_shiftop  in  2  shift operation
- id_is_shiftamt  in  5  shift amount
- id_is_regdest  in  5  destination register
- id_is_writereg  in  1  instruction writes regdest
- id_is_writeov  in  1  write even on overflow
- is_id_stall  out  1  combinational; decode must hold its instruction
- is_x_selalushift, is_x_selimregb, is_x_aluop[3], is_x_unsig, is_x_shiftop[2], is_x_shiftamt[5], is_x_rega[32], is_x_regb[32], is_x_imedext[32], is_x_regdest[5], is_x_writereg, is_x_writeov  out  registered issue bus to X unit
- is_stallcnt  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high, highest priority): all is_x_* outputs 0, all scoreboard counters 0, is_stallcnt 0.
- Scoreboard: one CNT_W counter per register 1..31. Register 0 is never pending and is never loaded.
- Each edge, every nonzero counter decrements by 1, saturating at 0.
- hazard = (uses_rs & rs!=0 & cnt[rs]!=0) | (uses_rt & rt!=0 & cnt[rt]!=0).
- is_id_stall = id_is_valid & hazard. Purely combinational; no dependence on the registered outputs.
- accept = id_is_valid & ~hazard.
- On accept, at the edge:
  - all id_is_* fields are copied to is_x_*, one-cycle latency.
  - if writereg & regdest!=0, cnt[regdest] is loaded with PEND_CYCLES. Load overrides decrement on the same edge, including a reload of an already-pending register (WAW).
- On no accept (invalid or stalled), at the edge: a bubble is issued. All is_x_* are 0, so is_x_writereg=0 and is_x_regdest=0.
- Overflow suppression happens downstream; the scoreboard always clears by count, independent of the overflow outcome.
- Self-dependency (rs == regdest of the same instruction) is not a hazard; the check uses pre-edge counters.
- Reset asserted mid-stall clears all pending state; the stalled instruction is accepted on the first cycle after reset if decode still presents it.

Optional Feature:
- ISSUE_STALLCNT_EN defined: is_stallcnt increments by 1 on every edge where is_id_stall=1. It wraps modulo 2^32 and clears on reset.
- Not defined: is_stallcnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold reset 2 cycles with id_is_valid=1 -> all is_x_* = 0, is_id_stall=0 after release, cnt all 0.
- Independent stream: ADD r3=r1+r2 then ADD r4=r5+r6 on consecutive cycles -> no stall; is_x_regdest = 3 then 4 on consecutive cycles.
- RAW: ADD r3 accepted at edge 0, then SUB r7=r3+r1 presented continuously -> is_id_stall=1 for exactly 5 cycles, SUB accepted at edge 6, bubbles (is_x_writereg=0) on the 5 intervening issue slots.
- r0 and unused sources: writer to r0, then a reader of r0 -> no stall. Reader with uses_rt=0 and rt=pending reg -> no stall.
- WAW reload: write r8 at edge 0, write r8 again at edge 2, reader of r8 presented -> stall until cnt reloaded at edge 2 reaches 0 (accepted at edge 8).
- ISSUE_STALLCNT_EN defined, RAW case above -> is_stallcnt = 5 afterwards; without the macro -> 0.

Source files
------------

// File: rtl/issue_x_scoreboard.sv
// issue_x_scoreboard
//   Issue stage directly upstream of the X execute unit. Checks the sources of
//   each decoded instruction against a per-register pending scoreboard. If a
//   source is still pending, decode is stalled and a bubble is sent downstream.
//   A hazard-free instruction is registered onto the is_x_* bus.
//
//   Ports
//     clock, reset         rising-edge clock, synchronous active-high reset
//     id_is_*              decoded instruction from decode (valid, sources,
//                          operands, control fields, destination)
//     is_id_stall          combinational stall back to decode
//     is_x_*               registered issue bus to the X unit (zero = bubble)
//     is_stallcnt          stall-cycle counter
//
//   Optional feature macro: ISSUE_STALLCNT_EN
//     defined   -> is_stallcnt counts stall edges (wraps modulo 2^32)
//     undefined -> is_stallcnt is tied to zero
//
//   Parameters
//     PEND_CYCLES  edges from issue until the destination is readable
//     CNT_W        counter width, 2^CNT_W > PEND_CYCLES
module issue_x_scoreboard #(
  parameter int unsigned PEND_CYCLES = 5,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [4:0]  id_is_rs,
  input  logic [4:0]  id_is_rt,
  input  logic        id_is_uses_rs,
  input  logic        id_is_uses_rt,
  input  logic [31:0] id_is_rega,
  input  logic [31:0] id_is_regb,
  input  logic [31:0] id_is_imedext,
  input  logic        id_is_selalushift,
  input  logic        id_is_selimregb,
  input  logic [2:0]  id_is_aluop,
  input  logic        id_is_unsig,
  input  logic [1:0]  id_is_shiftop,
  input  logic [4:0]  id_is_shiftamt,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic        id_is_writeov,
  output logic        is_id_stall,
  output logic        is_x_selalushift,
  output logic        is_x_selimregb,
  output logic [2:0]  is_x_aluop,
  output logic        is_x_unsig,
  output logic [1:0]  is_x_shiftop,
  output logic [4:0]  is_x_shiftamt,
  output logic [31:0] is_x_rega,
  output logic [31:0] is_x_regb,
  output logic [31:0] is_x_imedext,
  output logic [4:0]  is_x_regdest,
  output logic        is_x_writereg,
  output logic        is_x_writeov,
  output logic [31:0] is_stallcnt
);

  // cnt[0] is held at zero so r0 can never look pending.
  logic [CNT_W-1:0] cnt [32];
  logic             rs_busy;
  logic             rt_busy;
  logic             hazard;
  logic             accept;

  always_comb begin
    rs_busy     = id_is_uses_rs && (id_is_rs != 5'd0) && (cnt[id_is_rs] != '0);
    rt_busy     = id_is_uses_rt && (id_is_rt != 5'd0) && (cnt[id_is_rt] != '0);
    hazard      = rs_busy || rt_busy;
    is_id_stall = id_is_valid && hazard;
    accept      = id_is_valid && !hazard;
  end

  // Load on accept wins over the per-edge decrement, so a WAW re-write
  // restarts the full pending window.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned i = 1; i < 32; i++) begin
        if (accept && id_is_writereg && (id_is_regdest == 5'(i)))
          cnt[i] <= CNT_W'(PEND_CYCLES);
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Issue bus: a copy of the decode fields on accept, all-zero bubble otherwise.
  always_ff @(posedge clock) begin
    if (reset || !accept) begin
      is_x_selalushift <= 1'b0;
      is_x_selimregb   <= 1'b0;
      is_x_aluop       <= '0;
      is_x_unsig       <= 1'b0;
      is_x_shiftop     <= '0;
      is_x_shiftamt    <= '0;
      is_x_rega        <= '0;
      is_x_regb        <= '0;
      is_x_imedext     <= '0;
      is_x_regdest     <= '0;
      is_x_writereg    <= 1'b0;
      is_x_writeov     <= 1'b0;
    end else begin
      is_x_selalushift <= id_is_selalushift;
      is_x_selimregb   <= id_is_selimregb;
      is_x_aluop       <= id_is_aluop;
      is_x_unsig       <= id_is_unsig;
      is_x_shiftop     <= id_is_shiftop;
      is_x_shiftamt    <= id_is_shiftamt;
      is_x_rega        <= id_is_rega;
      is_x_regb        <= id_is_regb;
      is_x_imedext     <= id_is_imedext;
      is_x_regdest     <= id_is_regdest;
      is_x_writereg    <= id_is_writereg;
      is_x_writeov     <= id_is_writeov;
    end
  end

`ifdef ISSUE_STALLCNT_EN
  logic [31:0] stallcnt;

  always_ff @(posedge clock) begin
    if (reset)
      stallcnt <= '0;
    else if (is_id_stall)
      stallcnt <= stallcnt + 32'd1;
  end

  assign is_stallcnt = stallcnt;
`else
  assign is_stallcnt = '0;
`endif

endmodule

// File: tb/tb_issue_x_scoreboard.sv
// tb_issue_x_scoreboard
//   Self-checking bench for issue_x_scoreboard. The reference model records,
//   per register, the last edge index at which it is still pending
//   (acceptance edge + PEND_CYCLES); a source is a hazard when the upcoming
//   edge index is not past that value.
module tb_issue_x_scoreboard;

  localparam int PEND = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_is_valid = 1'b0;
  logic [4:0]  id_is_rs = '0;
  logic [4:0]  id_is_rt = '0;
  logic        id_is_uses_rs = 1'b0;
  logic        id_is_uses_rt = 1'b0;
  logic [31:0] id_is_rega = '0;
  logic [31:0] id_is_regb = '0;
  logic [31:0] id_is_imedext = '0;
  logic        id_is_selalushift = 1'b0;
  logic        id_is_selimregb = 1'b0;
  logic [2:0]  id_is_aluop = '0;
  logic        id_is_unsig = 1'b0;
  logic [1:0]  id_is_shiftop = '0;
  logic [4:0]  id_is_shiftamt = '0;
  logic [4:0]  id_is_regdest = '0;
  logic        id_is_writereg = 1'b0;
  logic        id_is_writeov = 1'b0;
  logic        is_id_stall;
  logic        is_x_selalushift;
  logic        is_x_selimregb;
  logic [2:0]  is_x_aluop;
  logic        is_x_unsig;
  logic [1:0]  is_x_shiftop;
  logic [4:0]  is_x_shiftamt;
  logic [31:0] is_x_rega;
  logic [31:0] is_x_regb;
  logic [31:0] is_x_imedext;
  logic [4:0]  is_x_regdest;
  logic        is_x_writereg;
  logic        is_x_writeov;
  logic [31:0] is_stallcnt;

  issue_x_scoreboard #(.PEND_CYCLES(PEND), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .id_is_valid(id_is_valid), .id_is_rs(id_is_rs), .id_is_rt(id_is_rt),
    .id_is_uses_rs(id_is_uses_rs), .id_is_uses_rt(id_is_uses_rt),
    .id_is_rega(id_is_rega), .id_is_regb(id_is_regb), .id_is_imedext(id_is_imedext),
    .id_is_selalushift(id_is_selalushift), .id_is_selimregb(id_is_selimregb),
    .id_is_aluop(id_is_aluop), .id_is_unsig(id_is_unsig),
    .id_is_shiftop(id_is_shiftop), .id_is_shiftamt(id_is_shiftamt),
    .id_is_regdest(id_is_regdest), .id_is_writereg(id_is_writereg),
    .id_is_writeov(id_is_writeov),
    .is_id_stall(is_id_stall),
    .is_x_selalushift(is_x_selalushift), .is_x_selimregb(is_x_selimregb),
    .is_x_aluop(is_x_aluop), .is_x_unsig(is_x_unsig),
    .is_x_shiftop(is_x_shiftop), .is_x_shiftamt(is_x_shiftamt),
    .is_x_rega(is_x_rega), .is_x_regb(is_x_regb), .is_x_imedext(is_x_imedext),
    .is_x_regdest(is_x_regdest), .is_x_writereg(is_x_writereg),
    .is_x_writeov(is_x_writeov), .is_stallcnt(is_stallcnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int edge_k = 0;
  int pend_until [32];
  int model_stalls = 0;
  int stall_seen = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_k);
    end
  endtask

  function automatic logic [127:0] dut_bus();
    return 128'({is_x_selalushift, is_x_selimregb, is_x_aluop, is_x_unsig,
                 is_x_shiftop, is_x_shiftamt, is_x_rega, is_x_regb,
                 is_x_imedext, is_x_regdest, is_x_writereg, is_x_writeov});
  endfunction

  function automatic logic [127:0] in_bus();
    return 128'({id_is_selalushift, id_is_selimregb, id_is_aluop, id_is_unsig,
                 id_is_shiftop, id_is_shiftamt, id_is_rega, id_is_regb,
                 id_is_imedext, id_is_regdest, id_is_writereg, id_is_writeov});
  endfunction

  function automatic logic [127:0] exp_stallcnt();
`ifdef ISSUE_STALLCNT_EN
    return 128'(model_stalls);
`else
    return 128'd0;
`endif
  endfunction

  // Present an instruction (random payload) just after the falling edge.
  task automatic present(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit wr);
    @(negedge clock);
    id_is_valid       = v;
    id_is_rs          = 5'(rs);
    id_is_rt          = 5'(rt);
    id_is_uses_rs     = urs;
    id_is_uses_rt     = urt;
    id_is_regdest     = 5'(rd);
    id_is_writereg    = wr;
    id_is_rega        = $urandom;
    id_is_regb        = $urandom;
    id_is_imedext     = $urandom;
    id_is_selalushift = 1'($urandom);
    id_is_selimregb   = 1'($urandom);
    id_is_aluop       = 3'($urandom);
    id_is_unsig       = 1'($urandom);
    id_is_shiftop     = 2'($urandom);
    id_is_shiftamt    = 5'($urandom);
    id_is_writeov     = 1'($urandom);
  endtask

  // One clock edge with the currently presented inputs, checked against the model.
  task automatic step(input bit do_reset);
    bit hz, acc;
    logic [127:0] exp_bus;
    reset = do_reset;
    hz = (id_is_uses_rs && id_is_rs != 0 && edge_k <= pend_until[id_is_rs]) ||
         (id_is_uses_rt && id_is_rt != 0 && edge_k <= pend_until[id_is_rt]);
    acc = id_is_valid && !hz && !do_reset;
    #1;
    if (!do_reset) begin
      check("stall", 128'(is_id_stall), 128'(id_is_valid && hz));
      if (is_id_stall === 1'b1) stall_seen++;
    end
    exp_bus = acc ? in_bus() : 128'd0;
    @(posedge clock);
    if (do_reset) begin
      foreach (pend_until[i]) pend_until[i] = -100;
      model_stalls = 0;
    end else begin
      if (id_is_valid && hz) model_stalls++;
      if (acc && id_is_writereg && id_is_regdest != 0)
        pend_until[id_is_regdest] = edge_k + PEND;
    end
    edge_k++;
    #1;
    check("bus", dut_bus(), exp_bus);
    check("stallcnt", 128'(is_stallcnt), exp_stallcnt());
    reset = 1'b0;
  endtask

  int n;

  initial begin
    foreach (pend_until[i]) pend_until[i] = -100;

    // Reset held two cycles with a valid instruction presented.
    present(1, 1, 2, 1, 1, 3, 1);
    step(1);
    step(1);
    present(1, 3, 4, 1, 1, 5, 1);
    #1 check("post_reset_stall", 128'(is_id_stall), 128'd0);
    check("post_reset_bus", dut_bus(), 128'd0);
    step(0);
    step(1);

    // Independent stream: r3=r1+r2 then r4=r5+r6.
    present(1, 1, 2, 1, 1, 3, 1);
    step(0);
    check("indep_rd0", 128'(is_x_regdest), 128'd3);
    present(1, 5, 6, 1, 1, 4, 1);
    step(0);
    check("indep_rd1", 128'(is_x_regdest), 128'd4);
    present(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0);

    // RAW: r3 written, then r7=r3+r1 presented until accepted.
    step(1);
    present(1, 1, 2, 1, 1, 3, 1);
    step(0);
    present(1, 3, 1, 1, 1, 7, 1);
    stall_seen = 0;
    n = 0;
    while (n < 20) begin
      step(0);
      n++;
      if (is_x_writereg === 1'b1) break;
    end
    check("raw_accept_edge", 128'(n), 128'd6);
    check("raw_stall_cycles", 128'(stall_seen), 128'd5);
    check("raw_rd", 128'(is_x_regdest), 128'd7);
`ifdef ISSUE_STALLCNT_EN
    check("raw_stallcnt", 128'(is_stallcnt), 128'd5);
`else
    check("raw_stallcnt", 128'(is_stallcnt), 128'd0);
`endif

    // r0 never pending; unused source ignored.
    present(1, 0, 0, 0, 0, 0, 1);
    step(0);
    present(1, 0, 0, 1, 1, 9, 1);
    #1 check("r0_nostall", 128'(is_id_stall), 128'd0);
    step(0);
    present(1, 0, 9, 1, 0, 10, 1);
    #1 check("unused_rt_nostall", 128'(is_id_stall), 128'd0);
    step(0);
    present(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0);

    // WAW reload: r8 written at edge 0 and edge 2, reader accepted at edge 8.
    present(1, 1, 2, 1, 1, 8, 1);
    step(0);
    present(0, 0, 0, 0, 0, 0, 0);
    step(0);
    present(1, 1, 2, 1, 1, 8, 1);
    step(0);
    present(1, 8, 0, 1, 0, 11, 1);
    n = 0;
    while (n < 20) begin
      step(0);
      n++;
      if (is_x_writereg === 1'b1) break;
    end
    check("waw_accept_edge", 128'(n + 2), 128'd8);

    // Mid-stall reset: stalled reader is accepted on the first cycle after reset.
    present(1, 1, 2, 1, 1, 12, 1);
    step(0);
    present(1, 12, 0, 1, 0, 13, 1);
    step(0);
    step(1);
    step(0);
    check("reset_mid_stall_accept", 128'(is_x_regdest), 128'd13);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      present(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom));
      step($urandom_range(0, 59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
